// File: rtl/sfu_ctrl.sv
// Sequencer for the SFU accumulation path: OFIFO -> SFU -> psum SRAM, num_pass x num_out vectors per job.
// Optional macro SFU_CTRL_RELU_EN clamps negative lanes to zero on the final-pass write-back.
module sfu_ctrl #(
  parameter  int col      = 8,
  parameter  int psum_bw  = 16,
  parameter  int num_pass = 9,
  parameter  int num_out  = 16,
  parameter  int addr_bw  = 4,
  localparam int pass_w   = $clog2(num_pass + 1),
  localparam int vec_w    = psum_bw * col
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                ofifo_valid,
  input  logic [vec_w-1:0]    ofifo_out,
  output logic                ofifo_rd,
  output logic                sfu_acc,
  output logic [vec_w-1:0]    sfu_psum_in,
  input  logic [vec_w-1:0]    sfu_out,
  output logic                pmem_ren,
  output logic                pmem_wen,
  output logic [addr_bw-1:0]  pmem_addr,
  output logic [vec_w-1:0]    pmem_wdata,
  input  logic [vec_w-1:0]    pmem_rdata,
  output logic [pass_w-1:0]   pass_idx,
  output logic [addr_bw-1:0]  out_idx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_LOAD,
    ST_ACC,
    ST_WB,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [pass_w-1:0]   pass_idx_q, pass_idx_d;
  logic [addr_bw-1:0]  out_idx_q, out_idx_d;
  logic [vec_w-1:0]    vec_q, vec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ofifo_rd_q, ofifo_rd_d;
  logic                sfu_acc_q, sfu_acc_d;
  logic                pmem_ren_q, pmem_ren_d;
  logic                pmem_wen_q, pmem_wen_d;
  logic [addr_bw-1:0]  pmem_addr_q, pmem_addr_d;
  logic                last_out, last_pass;
  logic [vec_w-1:0]    wb_data;

  assign last_out  = (out_idx_q == addr_bw'(num_out - 1));
  assign last_pass = (pass_idx_q == pass_w'(num_pass - 1));

  // Control outputs are decoded from the next state so they are flop outputs in the state they belong to.
  always_comb begin
    state_d     = state_q;
    pass_idx_d  = pass_idx_q;
    out_idx_d   = out_idx_q;
    vec_d       = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_WAIT;
          pass_idx_d = '0;
          out_idx_d  = '0;
        end
      end
      ST_WAIT: begin
        if (ofifo_valid) state_d = ST_RD;
      end
      ST_RD: begin
        vec_d   = ofifo_out;
        state_d = (pass_idx_q != '0) ? ST_LOAD : ST_ACC;
      end
      ST_LOAD: state_d = ST_ACC;
      ST_ACC:  state_d = ST_WB;
      ST_WB: begin
        if (last_out) begin
          out_idx_d  = '0;
          pass_idx_d = pass_idx_q + pass_w'(1);
        end else begin
          out_idx_d  = out_idx_q + addr_bw'(1);
        end
        state_d = (last_out && last_pass) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    ofifo_rd_d  = (state_d == ST_RD);
    pmem_ren_d  = (state_d == ST_RD) && (pass_idx_q != '0);
    pmem_wen_d  = (state_d == ST_WB);
    sfu_acc_d   = (state_d == ST_ACC) && (pass_idx_q != '0);
    pmem_addr_d = (pmem_ren_d || pmem_wen_d) ? out_idx_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pass_idx_q  <= '0;
      out_idx_q   <= '0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ofifo_rd_q  <= 1'b0;
      sfu_acc_q   <= 1'b0;
      pmem_ren_q  <= 1'b0;
      pmem_wen_q  <= 1'b0;
      pmem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pass_idx_q  <= pass_idx_d;
      out_idx_q   <= out_idx_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ofifo_rd_q  <= ofifo_rd_d;
      sfu_acc_q   <= sfu_acc_d;
      pmem_ren_q  <= pmem_ren_d;
      pmem_wen_q  <= pmem_wen_d;
      pmem_addr_q <= pmem_addr_d;
    end
  end

  always_comb begin
    wb_data = sfu_out;
`ifdef SFU_CTRL_RELU_EN
    if (last_pass) begin
      for (int l = 0; l < col; l++) begin
        if (sfu_out[l*psum_bw + psum_bw - 1]) wb_data[l*psum_bw +: psum_bw] = '0;
      end
    end
`endif
  end

  // Data paths follow the registered state; memory read data only exists during LOAD.
  always_comb begin
    case (state_q)
      ST_LOAD: sfu_psum_in = pmem_rdata;
      ST_ACC:  sfu_psum_in = vec_q;
      default: sfu_psum_in = '0;
    endcase
    pmem_wdata = (state_q == ST_WB) ? wb_data : '0;
  end

  // Side-effecting strobes are masked while reset is sampled so an aborted cycle never pops or touches memory.
  assign ofifo_rd  = ofifo_rd_q & ~reset;
  assign pmem_ren  = pmem_ren_q & ~reset;
  assign pmem_wen  = pmem_wen_q & ~reset;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sfu_acc   = sfu_acc_q;
  assign pmem_addr = pmem_addr_q;
  assign pass_idx  = pass_idx_q;
  assign out_idx   = out_idx_q;

endmodule

// File: doc/sfu_ctrl.md
# sfu_ctrl

Sequencer for the SFU accumulation path: pops partial-sum vectors from the output FIFO, drives the SFU's `acc_i`/`psum_in` to combine each vector with the running partial read from psum memory, and writes the result back. It runs one job of `num_pass` passes × `num_out` output vectors, for example 9 kernel positions × 16 output pixels. It sits between the OFIFO, the `sfu` instance and the psum SRAM.

## Interface
- `col`, 8, lanes per vector
- `psum_bw`, 16, bits per lane
- `num_pass`, 9, accumulation passes per job (≥1)
- `num_out`, 16, output vectors per pass (≥1, ≤2^`addr_bw`)
- `addr_bw`, 4, psum memory address width

- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin job; sampled only in IDLE
- `busy`  out  1  high from the cycle after accepted `start` through the DONE cycle
- `done`  out  1  one-cycle pulse in DONE
- `ofifo_valid`  in  1  FIFO non-empty; `ofifo_out` is valid (show-ahead)
- `ofifo_out`  in  `psum_bw*col`  head vector
- `ofifo_rd`  out  1  pop
- `sfu_acc`  out  1  to SFU `acc_i`
- `sfu_psum_in`  out  `psum_bw*col`  to SFU `psum_in`
- `sfu_out`  in  `psum_bw*col`  from SFU `psum_out`
- `pmem_ren`, `pmem_wen`  out  1  psum memory read/write enables
- `pmem_addr`  out  `addr_bw`  shared address
- `pmem_wdata`  out  `psum_bw*col`  write data
- `pmem_rdata`  in  `psum_bw*col`  read data, valid one cycle after `pmem_ren`
- `pass_idx`  out  `$clog2(num_pass+1)`  current pass
- `out_idx`  out  `addr_bw`  current output index

## Operation
- SFU contract: registered lane-wise, `psum_out <= acc_i ? psum_out + psum_in : psum_in`, 1-cycle latency, wrap-around two's-complement add.
- States: IDLE, WAIT, RD, LOAD, ACC, WB, DONE.
- IDLE: `start`=1 → WAIT; clear `pass_idx`, `out_idx`.
- WAIT: `ofifo_valid`=1 → RD; otherwise hold. Stalling is unbounded.
- RD:
  - assert `ofifo_rd` and capture `ofifo_out` into `vec_q`.
  - if `pass_idx`>0, assert `pmem_ren` with `pmem_addr`=`out_idx`, then go to LOAD.
  - else go to ACC.
- LOAD: `sfu_acc`=0, `sfu_psum_in`=`pmem_rdata`. Next state ACC.
- ACC: `sfu_psum_in`=`vec_q`; `sfu_acc`=1 if `pass_idx`>0, else 0. Next state WB.
- WB: `pmem_wen`=1, `pmem_addr`=`out_idx`, `pmem_wdata`=`sfu_out`. Then advance:
  - if `out_idx`=`num_out`-1, set `out_idx`=0 and `pass_idx`+=1.
  - else `out_idx`+=1.
  - if this was the last pass and last output → DONE; else → WAIT.
- DONE: `done`=1, `busy`=1, then IDLE. `pass_idx` and `out_idx` hold their final wrapped values until the next `start`.
- `start` outside IDLE is ignored.
- Read and write never occur in the same cycle.
- Idle drive (any state not driving them): `sfu_acc`=0, `sfu_psum_in`=0, `pmem_*` enables 0, `pmem_addr`=0, `pmem_wdata`=0.

## Timing
- Reset (any state, mid-job included) forces IDLE next cycle. All outputs, `vec_q` and counters go to 0. No pop, read or write occurs in the reset cycle. Partially accumulated memory contents are not cleaned.
- Per-vector cost, `ofifo_valid` already high: pass 0 takes 4 cycles (WAIT, RD, ACC, WB); later passes take 5 cycles (WAIT, RD, LOAD, ACC, WB).
- Minimum job length: 1 (IDLE) + `num_out`·(4 + 5·(`num_pass`−1)) + 1 (DONE).
- `ofifo_rd` is asserted only in RD, exactly once per vector. It is never asserted when `ofifo_valid`=0.
- `sfu_out` sampled in WB reflects the LOAD/ACC pair (or the single ACC on pass 0).

## Configuration
- `SFU_CTRL_RELU_EN` defined: in WB of the final pass (`pass_idx`=`num_pass`-1), each lane of `pmem_wdata` whose MSB is 1 is written as 0. Earlier passes write raw sums.
- Undefined: every pass writes `sfu_out` unmodified.

## Test plan
- Config `num_pass`=1, `num_out`=2. FIFO holds vectors with all lanes 0x0003, then all lanes 0x0005; pulse `start` → pmem[0]=all 0x0003, pmem[1]=all 0x0005; `pmem_ren` never high; `done` at cycle 10 after `start`.
- Config `num_pass`=3, `num_out`=1. Feed all-lane values 0x0001, 0x0002, 0x0004 → pmem[0]=all 0x0007; `sfu_acc` pattern per pass = ACC:0; LOAD:0, ACC:1; LOAD:0, ACC:1.
- Hold `ofifo_valid`=0 for 20 cycles in WAIT → no `ofifo_rd`, no pmem access, `busy`=1; then raise `ofifo_valid` → RD the following cycle.
- Assert `reset` during ACC of pass 1 → next cycle all outputs 0 and IDLE. A new `start` with fresh data produces correct sums with `pass_idx` restarting at 0.
- Wrap-around: pass 0 all lanes 0x7FFF, pass 1 all lanes 0x0001 → all lanes 0x8000. With `SFU_CTRL_RELU_EN` (2 passes), stored value is 0x0000.
- Pulse `start` while `busy` → ignored; exactly one `done` per job.
